sync_fifo_flex: RTL and testbench

//   Synchronous single-clock FIFO, next generation of the team's buffering block.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ram.sv | 22 ++
 rtl/sync_fifo_flex.sv | 119 +++++++++++
 tb/tb_sync_fifo_flex.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the flexible synchronous FIFO: read mode, count-width helper,
// and the registered status-flag bundle.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_status_t;

    // Width able to hold 0..depth inclusive.
    function automatic int cw_f(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage array: synchronous write, asynchronous read.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard/FWFT read, any depth >= 2, registered flags and sticky errors.
// Define SYNC_FIFO_FLEX_STATS_EN to build the peak_count high-water tracker.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [cw_f(DEPTH)-1:0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err,
    output logic [cw_f(DEPTH)-1:0]   peak_count
);

    localparam int CW = cw_f(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam fifo_status_t  RST_ST  = '{full: 1'b0, almost_full: (AF_LEVEL == 0),
                                          empty: 1'b1, almost_empty: 1'b1};

    fifo_status_t          st, st_next;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A read frees a slot in the same cycle, so a full FIFO can still take a write.
    assign rd_acc = rd_en & ~st.empty;
    assign wr_acc = wr_en & (~st.full | rd_acc);

    always_comb begin
        count_next = count;
        if (wr_acc & ~rd_acc)      count_next = count + 1'b1;
        else if (rd_acc & ~wr_acc) count_next = count - 1'b1;
        st_next.full         = (count_next == DEPTH_C);
        st_next.almost_full  = (count_next >= AF_C);
        st_next.empty        = (count_next == '0);
        st_next.almost_empty = (count_next <= AE_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            st        <= RST_ST;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count_next;
            st    <= st_next;
            if (wr_en & ~wr_acc) overflow <= 1'b1;
            else if (clr_err)    overflow <= 1'b0;
            if (rd_en & st.empty) underflow <= 1'b1;
            else if (clr_err)     underflow <= 1'b0;
        end
    end

    assign full         = st.full;
    assign almost_full  = st.almost_full;
    assign empty        = st.empty;
    assign almost_empty = st.almost_empty;

    fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign rd_data = st.empty ? '0 : ram_rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      rd_q <= '0;
                else if (rd_acc) rd_q <= ram_rdata;
            end
            assign rd_data = rd_q;
        end
    endgenerate

`ifdef SYNC_FIFO_FLEX_STATS_EN
    logic [CW-1:0] peak_q;
    // clr_err restarts tracking from the occupancy being entered this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   peak_q <= '0;
        else if (clr_err)             peak_q <= count_next;
        else if (count_next > peak_q) peak_q <= count_next;
    end
    assign peak_count = peak_q;
`else
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench for sync_fifo_flex: DEPTH=16 standard, DEPTH=5 standard, DEPTH=16 FWFT.
module tb_sync_fifo_flex;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mcnt [3];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    // instance 0: DEPTH 16 standard
    logic       wr0 = 0, rd0 = 0, clr0 = 0, full0, af0, empty0, ae0, ov0, un0;
    logic [7:0] wd0 = 0, rdd0;
    logic [4:0] cnt0, pk0;
    // instance 1: DEPTH 5 standard
    logic       wr1 = 0, rd1 = 0, clr1 = 0, full1, af1, empty1, ae1, ov1, un1;
    logic [7:0] wd1 = 0, rdd1;
    logic [2:0] cnt1, pk1;
    // instance 2: DEPTH 16 FWFT
    logic       wr2 = 0, rd2 = 0, clr2 = 0, full2, af2, empty2, ae2, ov2, un2;
    logic [7:0] wd2 = 0, rdd2;
    logic [4:0] cnt2, pk2;

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_data(wd0), .wr_en(wr0), .full(full0), .almost_full(af0),
        .rd_en(rd0), .rd_data(rdd0), .empty(empty0), .almost_empty(ae0), .count(cnt0),
        .overflow(ov0), .underflow(un0), .clr_err(clr0), .peak_count(pk0));

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_d5 (
        .clk(clk), .rst_n(rst_n), .wr_data(wd1), .wr_en(wr1), .full(full1), .almost_full(af1),
        .rd_en(rd1), .rd_data(rdd1), .empty(empty1), .almost_empty(ae1), .count(cnt1),
        .overflow(ov1), .underflow(un1), .clr_err(clr1), .peak_count(pk1));

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fw (
        .clk(clk), .rst_n(rst_n), .wr_data(wd2), .wr_en(wr2), .full(full2), .almost_full(af2),
        .rd_en(rd2), .rd_data(rdd2), .empty(empty2), .almost_empty(ae2), .count(cnt2),
        .overflow(ov2), .underflow(un2), .clr_err(clr2), .peak_count(pk2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on instance k and advance the scoreboard; exp is the popped word.
    task automatic cyc(input int k, input logic w, input logic [7:0] d, input logic r,
                       output logic racc, output logic [7:0] exp);
        int   depth;
        logic wacc;
        depth = (k == 1) ? 5 : 16;
        racc  = r && (mcnt[k] != 0);
        wacc  = w && ((mcnt[k] != depth) || racc);
        exp   = 8'h00;
        if (racc) begin
            case (k)
                0: exp = q0.pop_front();
                1: exp = q1.pop_front();
                default: exp = q2.pop_front();
            endcase
        end
        if (wacc) begin
            case (k)
                0: q0.push_back(d);
                1: q1.push_back(d);
                default: q2.push_back(d);
            endcase
        end
        mcnt[k] = mcnt[k] + int'(wacc) - int'(racc);
        case (k)
            0: begin wr0 = w; wd0 = d; rd0 = r; end
            1: begin wr1 = w; wd1 = d; rd1 = r; end
            default: begin wr2 = w; wd2 = d; rd2 = r; end
        endcase
        step();
    endtask

    task automatic idle();
        wr0 = 0; rd0 = 0; clr0 = 0;
        wr1 = 0; rd1 = 0; clr1 = 0;
        wr2 = 0; rd2 = 0; clr2 = 0;
    endtask

    task automatic test_reset();
        logic [4:0] exp_pk;
        exp_pk = 5'd0;
        checks++; if ({full0, af0, empty0, ae0, ov0, un0} !== 6'b001100) begin
            errors++; $display("FAIL reset_flags got %b exp 001100", {full0, af0, empty0, ae0, ov0, un0}); end
        checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt0); end
        checks++; if (rdd0 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", rdd0); end
        checks++; if (pk0 !== exp_pk) begin errors++; $display("FAIL reset_peak got %0d exp %0d", pk0, exp_pk); end
        checks++; if ({empty2, rdd2} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL reset_fwft got empty=%b data=%0h exp 1/0", empty2, rdd2); end
    endtask

    task automatic test_underflow();
        logic ra; logic [7:0] e;
        cyc(0, 1'b0, 8'h00, 1'b1, ra, e); idle();
        checks++; if ({un0, cnt0, rdd0} !== {1'b1, 5'd0, 8'h00}) begin
            errors++; $display("FAIL underflow got un=%b cnt=%0d data=%0h exp 1/0/0", un0, cnt0, rdd0); end
        clr0 = 1; step(); clr0 = 0;
        checks++; if (un0 !== 1'b0) begin errors++; $display("FAIL underflow_clr got %b exp 0", un0); end
        // write and read on empty: write lands, read rejected
        cyc(0, 1'b1, 8'h77, 1'b1, ra, e); idle();
        checks++; if ({un0, cnt0, empty0} !== {1'b1, 5'd1, 1'b0}) begin
            errors++; $display("FAIL empty_wr_rd got un=%b cnt=%0d empty=%b exp 1/1/0", un0, cnt0, empty0); end
        cyc(0, 1'b0, 8'h00, 1'b1, ra, e); idle();
        checks++; if ({rdd0, empty0} !== {e, 1'b1}) begin
            errors++; $display("FAIL empty_wr_rd_data got %0h/%b exp %0h/1", rdd0, empty0, e); end
        clr0 = 1; step(); clr0 = 0;
    endtask

    task automatic test_fill();
        logic ra; logic [7:0] e; logic [4:0] exp_pk;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1'b1, 8'(i), 1'b0, ra, e);
            checks++;
            if ({cnt0, af0, full0, ae0} !== {5'(i + 1), (i + 1 >= 14), (i == 15), (i + 1 <= 2)}) begin
                errors++; $display("FAIL fill_%0d got cnt=%0d af=%b full=%b ae=%b exp %0d/%b/%b/%b", i,
                    cnt0, af0, full0, ae0, i + 1, (i + 1 >= 14), (i == 15), (i + 1 <= 2)); end
        end
        idle();
`ifdef SYNC_FIFO_FLEX_STATS_EN
        exp_pk = 5'd16;
`else
        exp_pk = 5'd0;
`endif
        checks++; if (pk0 !== exp_pk) begin errors++; $display("FAIL fill_peak got %0d exp %0d", pk0, exp_pk); end
    endtask

    task automatic test_overflow();
        logic ra; logic [7:0] e;
        cyc(0, 1'b1, 8'hEE, 1'b0, ra, e); idle();
        checks++; if ({ov0, cnt0, full0} !== {1'b1, 5'd16, 1'b1}) begin
            errors++; $display("FAIL overflow got ov=%b cnt=%0d full=%b exp 1/16/1", ov0, cnt0, full0); end
        clr0 = 1; cyc(0, 1'b1, 8'hEE, 1'b0, ra, e); idle();
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL overflow_set_wins got %b exp 1", ov0); end
        clr0 = 1; step(); clr0 = 0;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL overflow_clr got %b exp 0", ov0); end
    endtask

    task automatic test_full_rw();
        logic ra; logic [7:0] e;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1'b1, 8'h80 + 8'(i), 1'b1, ra, e);
            checks++; if ({rdd0, cnt0, full0} !== {e, 5'd16, 1'b1}) begin
                errors++; $display("FAIL full_rw_%0d got data=%0h cnt=%0d full=%b exp %0h/16/1", i, rdd0, cnt0, full0, e); end
        end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1'b0, 8'h00, 1'b1, ra, e);
            checks++; if (rdd0 !== e) begin errors++; $display("FAIL drain_%0d got %0h exp %0h", i, rdd0, e); end
        end
        idle();
        checks++; if ({cnt0, empty0, ae0, af0} !== {5'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL drain_end got cnt=%0d empty=%b ae=%b af=%b exp 0/1/1/0", cnt0, empty0, ae0, af0); end
    endtask

    task automatic test_wrap();
        logic ra; logic [7:0] e;
        for (int i = 0; i < 14; i++) begin
            if (i < 12) cyc(1, 1'b1, 8'h30 + 8'(i), (i >= 4), ra, e);
            else        cyc(1, 1'b0, 8'h00, 1'b1, ra, e);
            if (ra) begin
                checks++; if (rdd1 !== e) begin errors++; $display("FAIL wrap_data_%0d got %0h exp %0h", i, rdd1, e); end
            end
            checks++; if ({cnt1, full1} !== {3'(mcnt[1]), (mcnt[1] == 5)}) begin
                errors++; $display("FAIL wrap_cnt_%0d got %0d/%b exp %0d", i, cnt1, full1, mcnt[1]); end
        end
        idle();
    endtask

    task automatic test_fwft();
        logic ra; logic [7:0] e; logic [7:0] head;
        cyc(2, 1'b1, 8'hA5, 1'b0, ra, e); idle();
        checks++; if ({empty2, rdd2, cnt2} !== {1'b0, 8'hA5, 5'd1}) begin
            errors++; $display("FAIL fwft_first got empty=%b data=%0h cnt=%0d exp 0/a5/1", empty2, rdd2, cnt2); end
        cyc(2, 1'b1, 8'h5A, 1'b0, ra, e);
        cyc(2, 1'b1, 8'h3C, 1'b0, ra, e); idle();
        checks++; if (rdd2 !== 8'hA5) begin errors++; $display("FAIL fwft_hold got %0h exp a5", rdd2); end
        for (int i = 0; i < 3; i++) begin
            head = q2[0];
            checks++; if (rdd2 !== head) begin errors++; $display("FAIL fwft_head_%0d got %0h exp %0h", i, rdd2, head); end
            cyc(2, 1'b0, 8'h00, 1'b1, ra, e);
        end
        idle();
        checks++; if ({empty2, cnt2} !== {1'b1, 5'd0}) begin
            errors++; $display("FAIL fwft_empty got %b/%0d exp 1/0", empty2, cnt2); end
    endtask

    task automatic test_reset_mid();
        logic ra; logic [7:0] e;
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 8'h60 + 8'(i), 1'b0, ra, e);
        idle();
        #2 rst_n = 0;
        #1;
        checks++; if ({cnt0, empty0, rdd0} !== {5'd0, 1'b1, 8'h00}) begin
            errors++; $display("FAIL reset_mid got cnt=%0d empty=%b data=%0h exp 0/1/0", cnt0, empty0, rdd0); end
        @(negedge clk) rst_n = 1;
        q0.delete(); q1.delete(); q2.delete();
        mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
        step();
        cyc(0, 1'b1, 8'h42, 1'b0, ra, e);
        cyc(0, 1'b0, 8'h00, 1'b1, ra, e); idle();
        checks++; if ({rdd0, empty0} !== {8'h42, 1'b1}) begin
            errors++; $display("FAIL reset_mid_after got %0h/%b exp 42/1", rdd0, empty0); end
    endtask

    initial begin
        mcnt[0] = 0; mcnt[1] = 0; mcnt[2] = 0;
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        step();
        test_reset();
        test_underflow();
        test_fill();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_fwft();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
